// File: rtl/mul5_sched.sv
// Round-robin scheduler sharing one 5x5 multiplier between two requesters; 3 cycles per op.
// Requesters hold req until done; a served requester must drop req for a cycle before regrant.

module mul5 (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic [9:0] y
);
   always_comb begin
      y = '0;
      for (int i = 0; i < 5; i++) begin
         if (b[i]) y = y + (10'(a) << i);
      end
   end
endmodule

module mul5_sched #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [4:0]       f0,
   input  logic [4:0]       m0,
   input  logic             req1,
   input  logic [4:0]       f1,
   input  logic [4:0]       m1,
   output logic             done0,
   output logic             done1,
   output logic [9:0]       p,
   output logic             busy,
   output logic             gnt_id,
   output logic [CNT_W-1:0] ops
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [4:0] op_f;
   logic [4:0] op_m;
   logic [1:0] blk;
   logic       last;
   logic [9:0] prod;
   logic       elig0;
   logic       elig1;
   logic       sel;
   logic [1:0] blk_set;

   mul5 u_mul5 (
      .a (op_f),
      .b (op_m),
      .y (prod)
   );

   assign elig0 = req0 & ~blk[0];
   assign elig1 = req1 & ~blk[1];
   // On a tie the requester that was not served last wins.
   assign sel   = (elig0 & elig1) ? ~last : elig1;

   assign blk_set = (state == MUL) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

   assign busy  = (state == MUL) || (state == DONE);
   assign done0 = (state == DONE) && !gnt_id;
   assign done1 = (state == DONE) && gnt_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_f   <= '0;
         op_m   <= '0;
         blk    <= '0;
         last   <= 1'b1;
         gnt_id <= 1'b0;
         p      <= '0;
         ops    <= '0;
      end else begin
         // A low request always unblocks, even on the edge that would block it.
         blk <= (blk | blk_set) & {req1, req0};
         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  op_f   <= sel ? f1 : f0;
                  op_m   <= sel ? m1 : m0;
                  gnt_id <= sel;
                  last   <= sel;
                  state  <= MUL;
               end
            end
            MUL: begin
               p     <= prod;
               ops   <= ops + CNT_W'(1);
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul5_sched.sv
// Directed bench for mul5_sched: table of single-requester ops plus multi-cycle sequences.

module tb_mul5_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [4:0] f0 = '0, m0 = '0, f1 = '0, m1 = '0;
   logic       done0, done1, busy, gnt_id;
   logic [9:0] p;
   logic [7:0] ops;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_ops = '0;

   mul5_sched #(.CNT_W(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .f0     (f0),
      .m0     (m0),
      .req1   (req1),
      .f1     (f1),
      .m1     (m1),
      .done0  (done0),
      .done1  (done1),
      .p      (p),
      .busy   (busy),
      .gnt_id (gnt_id),
      .ops    (ops)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [4:0] f;
      logic [4:0] m;
      logic [9:0] exp_p;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic nclk(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic set_req(input logic r, input logic v, input logic [4:0] f, input logic [4:0] m);
      if (r) begin req1 = v; f1 = f; m1 = m; end
      else   begin req0 = v; f0 = f; m0 = m; end
   endtask

   initial begin
      vecs[0] = '{1'b0, 5'd31, 5'd31, 10'd961};
      vecs[1] = '{1'b1, 5'd0,  5'd31, 10'd0};
      vecs[2] = '{1'b0, 5'd1,  5'd17, 10'd17};
      vecs[3] = '{1'b1, 5'd16, 5'd16, 10'd256};
      vecs[4] = '{1'b0, 5'd3,  5'd5,  10'd15};
      vecs[5] = '{1'b1, 5'd7,  5'd9,  10'd63};
      vecs[6] = '{1'b1, 5'd31, 5'd1,  10'd31};
      vecs[7] = '{1'b0, 5'd0,  5'd0,  10'd0};

      // Reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", {done1, done0}, 0);
      chk("rst_p", p, 0);
      chk("rst_gnt", gnt_id, 0);
      chk("rst_ops", ops, 0);

      // Simultaneous requests: requester 0 wins first tie
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 1, 5'd3, 5'd5);
      set_req(1, 1, 5'd7, 5'd9);
      nclk(1);
      chk("sim_busy0", busy, 1);
      chk("sim_gnt0", gnt_id, 0);
      nclk(1);
      chk("sim_done0", {done1, done0}, 2'b01);
      chk("sim_p0", p, 15);
      nclk(1);
      chk("sim_idle", busy, 0);
      nclk(1);
      chk("sim_busy1", busy, 1);
      chk("sim_gnt1", gnt_id, 1);
      nclk(1);
      chk("sim_done1", {done1, done0}, 2'b10);
      chk("sim_p1", p, 63);
      chk("sim_ops", ops, 2);
      exp_ops = 8'd2;
      // Both still held but both blocked: nothing is granted
      nclk(4);
      chk("sim_blocked", busy, 0);
      chk("sim_hold_p", p, 63);
      chk("sim_hold_gnt", gnt_id, 1);
      req0 = 0; req1 = 0;
      nclk(1);

      // Blocking: hold req0 after done0
      set_req(0, 1, 5'd2, 5'd4);
      nclk(2);
      chk("blk_done", done0, 1);
      chk("blk_p", p, 8);
      exp_ops++;
      for (int i = 0; i < 4; i++) begin
         nclk(1);
         chk("blk_nogrant", busy, 0);
      end
      req0 = 0;
      nclk(1);
      req0 = 1;
      nclk(1);
      chk("blk_regrant", busy, 1);
      nclk(1);
      chk("blk_done2", done0, 1);
      chk("blk_p2", p, 8);
      exp_ops++;
      chk("blk_ops", ops, 32'(exp_ops));
      req0 = 0;
      nclk(1);

      // Table of single-requester operations
      for (int k = 0; k < 8; k++) begin
         set_req(vecs[k].r, 1, vecs[k].f, vecs[k].m);
         nclk(1);
         chk("vec_busy", busy, 1);
         chk("vec_nodone", {done1, done0}, 0);
         nclk(1);
         exp_ops++;
         chk("vec_done", {done1, done0}, vecs[k].r ? 2'b10 : 2'b01);
         chk("vec_p", p, vecs[k].exp_p);
         chk("vec_gnt", gnt_id, vecs[k].r);
         chk("vec_ops", ops, 32'(exp_ops));
         set_req(vecs[k].r, 0, 5'd0, 5'd0);
         nclk(1);
         chk("vec_idle", {busy, done1, done0}, 0);
      end

      // Operand change after the grant edge has no effect
      set_req(0, 1, 5'd5, 5'd6);
      nclk(1);
      f0 = 5'd9;
      nclk(1);
      exp_ops++;
      chk("opchg_p", p, 30);
      chk("opchg_done", done0, 1);
      req0 = 0;
      nclk(1);

      // Request drop during MUL: done still pulses
      set_req(1, 1, 5'd4, 5'd5);
      nclk(1);
      req1 = 0;
      nclk(1);
      exp_ops++;
      chk("drop_done", done1, 1);
      chk("drop_p", p, 20);
      nclk(1);

      // ops wraps to zero
      while (exp_ops != 8'd0) begin
         set_req(0, 1, 5'd1, 5'd1);
         nclk(2);
         req0 = 0;
         exp_ops++;
         nclk(1);
      end
      chk("ops_wrap", ops, 0);

      // Reset during MUL aborts
      set_req(0, 1, 5'd10, 5'd3);
      nclk(1);
      chk("rmid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_out", {done1, done0, busy, gnt_id}, 0);
      chk("rmid_p", p, 0);
      chk("rmid_ops", ops, 0);
      nclk(1);
      req0 = 0;
      set_req(1, 1, 5'd6, 5'd7);
      chk("rmid_nodone", {done1, done0}, 0);
      rst_n = 1'b1;
      nclk(1);
      chk("rmid_gnt", gnt_id, 1);
      chk("rmid_busy2", busy, 1);
      nclk(1);
      chk("rmid_done1", {done1, done0}, 2'b10);
      chk("rmid_p2", p, 42);
      chk("rmid_ops2", ops, 1);
      req1 = 0;
      nclk(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
